ps2_kbd_decode: RTL
===================

PS2_KBD_DECODE -- requirements
Module: ps2_kbd_decode

Interface
REQ-001 SHALL have parameter DEPTH, default 8, event FIFO depth in entries (power of 2, 2..32).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port rx_code  input  8  received scan byte, valid when rx_done=1.
REQ-005 SHALL have port rx_done  input  1  one-cycle strobe: new byte on rx_code.
REQ-006 SHALL have port rx_err  input  1  OR of upstream frame/parity error, sampled only with rx_done.
REQ-007 SHALL have port evt_valid  output  1  FIFO not empty.
REQ-008 SHALL have port evt_code  output  8  head event scan code.
REQ-009 SHALL have port evt_ext  output  1  head event had E0 prefix.
REQ-010 SHALL have port evt_brk  output  1  head event is key release.
REQ-011 SHALL have port evt_rd  input  1  pop strobe; ignored when evt_valid=0.
REQ-012 SHALL have port mods  output  4  {caps_lock, alt, ctrl, shift} live modifier state.
REQ-013 SHALL have port ovf  output  1  sticky: event dropped, FIFO full.
REQ-014 SHALL have port err  output  1  sticky: rx_err seen, or 0x00/0xFF overrun code received.
REQ-015 SHALL have port clr  input  1  clears ovf and err; no effect on FIFO or modifiers.

Function
REQ-016 SHALL act only on cycles with rx_done=1; bytes are never buffered outside the FIFO.
REQ-017 SHALL implement states IDLE, EXT (E0 seen), BRK (F0 seen), EXTBRK (E0 F0 seen), PAUSE.
REQ-018 SHALL transition IDLE--E0->EXT, IDLE--F0->BRK, EXT--F0->EXTBRK, IDLE--E1->PAUSE with skip counter loaded 7.
REQ-019 SHALL, for any other byte in IDLE/EXT/BRK/EXTBRK, emit event {ext=state in EXT/EXTBRK, brk=state in BRK/EXTBRK, code=byte}, then return to IDLE.
REQ-020 SHALL in PAUSE decrement the skip counter per byte; at 0 emit {ext=1, brk=0, code=0x77}, return to IDLE; no other events meanwhile.
REQ-021 SHALL, when a received byte is E0 or F0 in any non-IDLE non-PAUSE state where the transition is undefined (e.g. E0 in BRK), set err and return to IDLE, no event.
REQ-022 SHALL discard bytes 0xAA, 0xFA, 0xEE, 0xFE in IDLE without event or error.
REQ-023 SHALL on rx_err=1 or byte 0x00/0xFF: set err, return to IDLE, no event, no modifier change.
REQ-024 SHALL write the event into the FIFO on the same edge rx_done is sampled; evt_valid rises the next cycle (latency 1).
REQ-025 SHALL, if full at write, drop the event and set ovf; simultaneous write and evt_rd when full SHALL accept both.
REQ-026 SHALL be first-word-fall-through: evt_code/ext/brk show head entry whenever evt_valid=1.
REQ-027 SHALL update mods on the event-emit edge regardless of FIFO full: shift = L(0x12) or R(0x59) held; ctrl = 0x14 or E0 14 held; alt = 0x11 or E0 11 held.
REQ-028 SHALL toggle caps_lock on make of 0x58 only if 0x58 was not already held (typematic repeats ignored).
REQ-029 SHALL give clr priority lower than a same-cycle set: set wins.

Reset
REQ-030 SHALL on rst=0 force state IDLE, skip counter 0, FIFO empty (evt_valid=0), mods=0, held-key flags 0, ovf=0, err=0, evt_code/ext/brk=0.
REQ-031 SHALL abandon any partial prefix or PAUSE sequence on reset mid-operation; next byte decodes from IDLE.

Structure
REQ-032 SHALL place state encoding and scan constants (E0, F0, E1, modifier codes, 0x58, 0x77, discard set) in shared package ps2_pkg.
REQ-033 SHALL implement the FIFO as sub-module ps2_evt_fifo (10-bit wide, DEPTH deep, FWFT, full/empty).

Verification
REQ-034 SHALL cover: bytes 1C, F0 1C -> events {0,0,1C},{0,1,1C}; evt_valid one cycle after each rx_done.
REQ-035 SHALL cover: E0 F0 75 -> single event {1,1,75}; E0 11 -> mods[2]=1, E0 F0 11 -> mods[2]=0.
REQ-036 SHALL cover: E1 14 77 E1 F0 14 F0 77 -> exactly one event {1,0,77}, mods unchanged.
REQ-037 SHALL cover: DEPTH+1 makes without evt_rd -> DEPTH entries, ovf=1; full plus simultaneous write/read -> count stays DEPTH, ovf unchanged.
REQ-038 SHALL cover: 58, 58, F0 58, 58 -> caps_lock 1 after first make, stays 1, toggles to 0 on second make.
REQ-039 SHALL cover: F0 then rx_err=1 byte -> err=1, IDLE; following 1C -> {0,0,1C}; rst=0 mid E0 -> next 1C gives ext=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared decoder state encoding, event layout and scan-code constants
package ps2_pkg;

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, PAUSE} state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_PAUSE  = 8'h77;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_OVR0   = 8'h00;
    localparam logic [7:0] SC_OVR1   = 8'hFF;

    // E1 is followed by seven more bytes of the Pause make sequence
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    function automatic logic is_discard(input logic [7:0] b);
        return b == SC_BAT || b == SC_ACK || b == SC_ECHO || b == SC_RESEND;
    endfunction

    function automatic logic is_overrun(input logic [7:0] b);
        return b == SC_OVR0 || b == SC_OVR1;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: first-word-fall-through event FIFO, accepts a write when full if a read happens too
module ps2_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] din,
    input  logic         rd,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         wr_ok, rd_ok;

    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd);
    assign dout  = empty ? '0 : mem[rp[AW-1:0]];

    // storage array, no reset needed since reads are gated by empty
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp[AW-1:0]] <= din;
    end

    // wrap-bit pointers distinguish full from empty
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_ok) wp <= wp + ONE;
            if (rd_ok) rp <= rp + ONE;
        end
    end

endmodule

// File: rtl/ps2_kbd_decode.sv
// ps2_kbd_decode: scan-code set 2 prefix decoder with modifier tracking and an event FIFO
module ps2_kbd_decode
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_code,
    input  logic       rx_done,
    input  logic       rx_err,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    input  logic       evt_rd,
    output logic [3:0] mods,
    output logic       ovf,
    output logic       err,
    input  logic       clr
);

    state_t     state, state_n;
    logic [2:0] skip, skip_n;
    logic       emit, err_set, ovf_set;
    evt_t       ev, head;
    logic       full, empty;
    logic       lshift, rshift, lctrl, rctrl, lalt, ralt, caps, caps_held;

    ps2_evt_fifo #(.DEPTH(DEPTH), .W(10)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (emit),
        .din   (ev),
        .rd    (evt_rd),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign evt_valid = !empty;
    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_brk   = head.brk;
    assign mods      = {caps, lalt | ralt, lctrl | rctrl, lshift | rshift};
    assign ovf_set   = emit && full && !evt_rd;

    // prefix / pause sequencing: decides next state, event emission and error flag per byte
    always_comb begin
        state_n = state;
        skip_n  = skip;
        emit    = 1'b0;
        err_set = 1'b0;
        ev      = '0;
        if (rx_done) begin
            if (rx_err || is_overrun(rx_code)) begin
                err_set = 1'b1;
                state_n = IDLE;
                skip_n  = '0;
            end else if (state == PAUSE) begin
                skip_n = skip - 3'd1;
                if (skip == 3'd1) begin
                    emit    = 1'b1;
                    ev      = '{ext: 1'b1, brk: 1'b0, code: SC_PAUSE};
                    state_n = IDLE;
                end
            end else if (state == IDLE && rx_code == SC_E0) begin
                state_n = EXT;
            end else if (state == IDLE && rx_code == SC_F0) begin
                state_n = BRK;
            end else if (state == EXT && rx_code == SC_F0) begin
                state_n = EXTBRK;
            end else if (state == IDLE && rx_code == SC_E1) begin
                state_n = PAUSE;
                skip_n  = PAUSE_SKIP;
            end else if (state == IDLE && is_discard(rx_code)) begin
                state_n = IDLE;
            end else if (rx_code == SC_E0 || rx_code == SC_F0) begin
                err_set = 1'b1;
                state_n = IDLE;
            end else begin
                emit    = 1'b1;
                ev      = '{ext: state == EXT || state == EXTBRK,
                            brk: state == BRK || state == EXTBRK,
                            code: rx_code};
                state_n = IDLE;
            end
        end
    end

    // state, sticky flags and held-key tracking; modifiers follow every emitted event even if dropped
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            skip      <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            lctrl     <= 1'b0;
            rctrl     <= 1'b0;
            lalt      <= 1'b0;
            ralt      <= 1'b0;
            caps      <= 1'b0;
            caps_held <= 1'b0;
        end else begin
            state <= state_n;
            skip  <= skip_n;
            err   <= err_set | (err & ~clr);
            ovf   <= ovf_set | (ovf & ~clr);
            if (emit && !ev.ext && ev.code == SC_LSHIFT) lshift <= !ev.brk;
            if (emit && !ev.ext && ev.code == SC_RSHIFT) rshift <= !ev.brk;
            if (emit && !ev.ext && ev.code == SC_CTRL)   lctrl  <= !ev.brk;
            if (emit &&  ev.ext && ev.code == SC_CTRL)   rctrl  <= !ev.brk;
            if (emit && !ev.ext && ev.code == SC_ALT)    lalt   <= !ev.brk;
            if (emit &&  ev.ext && ev.code == SC_ALT)    ralt   <= !ev.brk;
            if (emit && !ev.ext && ev.code == SC_CAPS) begin
                caps_held <= !ev.brk;
                if (!ev.brk && !caps_held) caps <= !caps;
            end
        end
    end

endmodule
